fb_rect_writer: RTL
===================

# fb_rect_writer

Framebuffer write engine for the VGA display path. It fills a clipped, solid-colour rectangle into the 320x240, 12-bit framebuffer block RAM through the RAM's write port (wea/addra/dina). The VGA side reads the same RAM at address (h_cnt>>1) + 320*(v_cnt>>1). Row-major layout: address = y*320 + x, range 0..76799.

## Interface
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- x0  in  9  rectangle left column
- y0  in  8  rectangle top row
- w  in  9  width in pixels
- h  in  8  height in pixels
- color  in  12  RGB444 fill value, {R,G,B}
- stall  in  1  when high, no write is issued and position is held
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse at completion
- wea  out  1  RAM write enable
- addra  out  17  RAM write address
- dina  out  12  RAM write data

## Operation
- States:
  - IDLE: if start=1, latch x0, y0, w, h and color, then go to SETUP. Otherwise stay.
  - SETUP:
    - Compute the clipped end points, both exclusive:
      - xe = min(x0+w, FB_W), 10-bit sum.
      - ye = min(y0+h, FB_H), 9-bit sum.
    - Compute row_base = y0*320 as (y0<<8)+(y0<<6), with no multiplier.
    - If w=0, h=0, x0>=FB_W or y0>=FB_H, the rectangle is empty: go to DONE.
    - Otherwise set x=x0, y=y0 and go to ROW.
  - ROW, at each edge with stall=0:
    - Drive wea=1, addra=row_base+x, dina=color.
    - If x+1<xe, then x++.
    - Else if y+1<ye, then x=x0, y++ and row_base+=320.
    - Else go to DONE.
    - With stall=1: wea=0 and x, y and row_base hold.
  - DONE: wea=0 and done=1 for one cycle, then go to IDLE.
- All outputs are registered.
- Reset values: busy=0, done=0, wea=0, addra=0, dina=0, state=IDLE.
- addra and dina hold their last values when wea=0.
- start while busy=1 is ignored and is not queued.
- Inputs other than start are don't-care outside the cycle where start is accepted.
- Clipping truncates the rectangle at the right and bottom edges. There is no wrap-around: addra never exceeds 76799.
- Reset asserted mid-operation: at once wea=0, busy=0, done=0 and state=IDLE. The partially written rectangle remains in RAM.

## Timing
- start is sampled at edge 0. N is the clipped pixel count, (xe-x0)*(ye-y0). Edges below assume no stall.
- Edge 1: busy=1, state=SETUP.
- Edges 2..N+1: one write per edge, wea=1, in row-major order.
- Edge N+2: wea=0, done=1, busy=1.
- Edge N+3: done=0, busy=0. A new start can be accepted at this edge.
- Empty rectangle: done=1 at edge 2, busy=0 at edge 3, and no wea pulse.
- Each stalled edge in ROW delays every later event by one edge.
- Throughput: 1 pixel per clock when unstalled. Per-request overhead is 3 clocks.

## Test plan
- Full clear: x0=0, y0=0, w=320, h=240, color=12'h000.
  - Expect exactly 76800 wea cycles, addra 0..76799 contiguous.
  - done at edge 76802; busy low at edge 76803.
- Small rectangle: x0=10, y0=5, w=3, h=2, color=12'hF00.
  - Expect addra sequence 1610, 1611, 1612, 1930, 1931, 1932, with dina=12'hF00.
  - done at edge 8.
- Clipping: x0=318, y0=239, w=5, h=4.
  - Expect only addra 76798 and 76799, then done.
  - x0=400 or w=0: no wea, done at edge 2.
- Stall: the small rectangle with stall high on edges 3 and 4.
  - Same 6 addresses with no duplicates or skips.
  - wea=0 on stalled edges; done at edge 10.
- Start while busy: second start with different colour at edge 4 of a running request.
  - Ignored; only the first rectangle is written and done pulses once.
- Reset mid-run: rst low during the ROW state of the full clear.
  - wea and busy drop without waiting for a clock edge.
  - After release, a new small-rectangle request behaves as in scenario 2.

Source files
------------

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: fills a clipped solid-colour rectangle into the 320x240 RGB444
// framebuffer RAM, one pixel per unstalled clock in row-major order.
module fb_rect_writer #(
    parameter int FB_W = 320,
    parameter int FB_H = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [7:0]  y0,
    input  logic [8:0]  w,
    input  logic [7:0]  h,
    input  logic [11:0] color,
    input  logic        stall,
    output logic        busy,
    output logic        done,
    output logic        wea,
    output logic [16:0] addra,
    output logic [11:0] dina
);
    typedef enum logic [1:0] {IDLE, SETUP, ROW, DONE} state_t;
    localparam logic [9:0]  X_MAX = 10'(FB_W);
    localparam logic [8:0]  Y_MAX = 9'(FB_H);
    localparam logic [16:0] PITCH = 17'(FB_W);
    state_t      state, state_nxt;
    logic [8:0]  x0_r, w_r, x, x_nxt;
    logic [7:0]  y0_r, h_r, y, y_nxt;
    logic [11:0] color_r, dina_nxt;
    logic [9:0]  x_sum, xe, xe_nxt;
    logic [8:0]  y_sum, ye, ye_nxt;
    logic [16:0] row_base, rb_nxt, addra_nxt;
    logic        busy_nxt, done_nxt, wea_nxt, empty;
    assign x_sum = {1'b0, x0_r} + {1'b0, w_r};
    assign y_sum = {1'b0, y0_r} + {1'b0, h_r};
    assign empty = (w_r == '0) || (h_r == '0) || ({1'b0, x0_r} >= X_MAX) || ({1'b0, y0_r} >= Y_MAX);
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        rb_nxt    = row_base;
        xe_nxt    = xe;
        ye_nxt    = ye;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        wea_nxt   = 1'b0;
        addra_nxt = addra;
        dina_nxt  = dina;
        case (state)
            IDLE: begin
                busy_nxt  = start;
                state_nxt = start ? SETUP : IDLE;
            end
            SETUP: begin
                xe_nxt    = (x_sum > X_MAX) ? X_MAX : x_sum;
                ye_nxt    = (y_sum > Y_MAX) ? Y_MAX : y_sum;
                rb_nxt    = ({9'd0, y0_r} << 8) + ({9'd0, y0_r} << 6);
                x_nxt     = x0_r;
                y_nxt     = y0_r;
                state_nxt = empty ? DONE : ROW;
            end
            ROW: begin
                if (!stall) begin
                    wea_nxt   = 1'b1;
                    addra_nxt = row_base + {8'd0, x};
                    dina_nxt  = color_r;
                    if ({1'b0, x} + 10'd1 < xe) begin
                        x_nxt = x + 9'd1;
                    end else if ({1'b0, y} + 9'd1 < ye) begin
                        x_nxt  = x0_r;
                        y_nxt  = y + 8'd1;
                        rb_nxt = row_base + PITCH;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            wea      <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            xe       <= '0;
            ye       <= '0;
            x0_r     <= '0;
            y0_r     <= '0;
            w_r      <= '0;
            h_r      <= '0;
            color_r  <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            wea      <= wea_nxt;
            addra    <= addra_nxt;
            dina     <= dina_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            row_base <= rb_nxt;
            xe       <= xe_nxt;
            ye       <= ye_nxt;
            if (state == IDLE && start) begin
                x0_r    <= x0;
                y0_r    <= y0;
                w_r     <= w;
                h_r     <= h;
                color_r <= color;
            end
        end
    end
endmodule
